// File: rtl/pwm_shadow_update_scheduler.sv
// Schedules the maskevent strobes that move staged compare values into the PWM
// shadow registers, one software request at a time, gated by carrier events.
module pwm_shadow_update_scheduler #(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_on,
  input  logic                 upd_req,
  input  logic [N_CH-1:0]      upd_chmask,
  input  logic [1:0]           upd_mode,
  input  logic [N_CH-1:0]      carr_zero,
  input  logic [N_CH-1:0]      carr_peak,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  output logic [N_CH-1:0]      maskevent,
  output logic                 upd_busy,
  output logic                 upd_done,
  output logic                 upd_timeout,
  output logic                 upd_reject
);

  typedef enum logic [1:0] {StIdle, StArmed, StCommit, StDone} state_e;

  state_e               state_q, state_d;
  logic [N_CH-1:0]      pending_q, pending_d;
  logic [1:0]           mode_q, mode_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]      maskevent_q, maskevent_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 reject_q, reject_d;

  logic [N_CH-1:0]      hit;
  logic [N_CH-1:0]      remain;
  logic [TIMEOUT_W:0]   cnt_inc;
  logic                 lim_hit;

  always_comb begin
    hit     = pending_q & (({N_CH{mode_q[0]}} & carr_zero) | ({N_CH{mode_q[1]}} & carr_peak));
    remain  = pending_q & ~hit;
    // One bit wider so a saturated counter never aliases a small limit.
    cnt_inc = {1'b0, cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    lim_hit = (timeout_lim != '0) && (cnt_inc == {1'b0, timeout_lim});
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    maskevent_d = '0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    reject_d    = upd_req && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (upd_req) begin
          pending_d = upd_chmask;
          mode_d    = upd_mode;
          cnt_d     = '0;
          if ((upd_mode == 2'b00) || !pwm_on || (upd_chmask == '0)) begin
            state_d     = StCommit;
            maskevent_d = upd_chmask;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (cnt_q != {TIMEOUT_W{1'b1}}) cnt_d = cnt_inc[TIMEOUT_W-1:0];
        maskevent_d = hit;
        pending_d   = remain;
        if (remain == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (lim_hit) begin
          maskevent_d = pending_q;
          pending_d   = '0;
          state_d     = StDone;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
        end else if (!pwm_on) begin
          // Shadows go transparent: flush everything still pending via COMMIT.
          maskevent_d = pending_q;
          pending_d   = pending_q;
          state_d     = StCommit;
        end
      end
      StCommit: begin
        pending_d = '0;
        state_d   = StDone;
        done_d    = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      mode_q      <= 2'b00;
      cnt_q       <= '0;
      maskevent_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      maskevent_q <= maskevent_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      reject_q    <= reject_d;
    end
  end

  assign maskevent   = maskevent_q;
  assign upd_busy    = (state_q != StIdle);
  assign upd_done    = done_q;
  assign upd_timeout = timeout_q;
  assign upd_reject  = reject_q;

endmodule

// File: tb/tb_pwm_shadow_update_scheduler.sv
// Bench for pwm_shadow_update_scheduler: directed scenarios then random traffic, all
// checked against a request-level schedule of expected outputs per cycle.
module tb_pwm_shadow_update_scheduler;

  localparam int NC = 2048;

  logic        clk;
  logic        reset;
  logic        pwm_on;
  logic        upd_req;
  logic [7:0]  upd_chmask;
  logic [1:0]  upd_mode;
  logic [7:0]  carr_zero;
  logic [7:0]  carr_peak;
  logic [15:0] timeout_lim;
  logic [7:0]  maskevent;
  logic        upd_busy;
  logic        upd_done;
  logic        upd_timeout;
  logic        upd_reject;

  pwm_shadow_update_scheduler #(
    .N_CH      (8),
    .TIMEOUT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_on      (pwm_on),
    .upd_req     (upd_req),
    .upd_chmask  (upd_chmask),
    .upd_mode    (upd_mode),
    .carr_zero   (carr_zero),
    .carr_peak   (carr_peak),
    .timeout_lim (timeout_lim),
    .maskevent   (maskevent),
    .upd_busy    (upd_busy),
    .upd_done    (upd_done),
    .upd_timeout (upd_timeout),
    .upd_reject  (upd_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_bad;
  int cyc;
  bit pwm_lvl;
  int lim;

  // Expected outputs indexed by absolute cycle number.
  logic [7:0] exp_me   [NC];
  bit         exp_done [NC];
  bit         exp_to   [NC];
  bit         exp_rej  [NC];
  bit         exp_busy [NC];

  // Request-level model: an outstanding request waiting on carrier events.
  bit         m_armed;
  int         m_start;
  logic [7:0] m_rem;
  logic [1:0] m_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit rq, input logic [7:0] mk, input logic [1:0] md,
                       input logic [7:0] z, input logic [7:0] pk);
    int         c;
    int         elapsed;
    logic [7:0] hit;
    c = cyc;
    if (r) begin
      for (int k = 1; k <= 2; k++) begin
        exp_me[c+k]   = '0;
        exp_done[c+k] = 1'b0;
        exp_to[c+k]   = 1'b0;
        exp_rej[c+k]  = 1'b0;
        exp_busy[c+k] = 1'b0;
      end
      m_armed = 1'b0;
      return;
    end
    if (rq) begin
      if (exp_busy[c]) begin
        exp_rej[c+1] = 1'b1;
      end else if (md == 2'b00 || !pwm_lvl || mk == 8'h00) begin
        exp_me[c+1]   = mk;
        exp_busy[c+1] = 1'b1;
        exp_busy[c+2] = 1'b1;
        exp_done[c+2] = 1'b1;
      end else begin
        m_armed       = 1'b1;
        m_start       = c + 1;
        m_rem         = mk;
        m_mode        = md;
        exp_busy[c+1] = 1'b1;
      end
    end
    if (m_armed && c >= m_start) begin
      hit = m_rem & ((m_mode[0] ? z : 8'h00) | (m_mode[1] ? pk : 8'h00));
      elapsed = c - m_start + 1;
      exp_busy[c+1] = 1'b1;
      if ((m_rem & ~hit) == 8'h00) begin
        exp_me[c+1]   = hit;
        exp_done[c+1] = 1'b1;
        m_armed       = 1'b0;
      end else if (lim != 0 && elapsed == lim) begin
        exp_me[c+1]   = m_rem;
        exp_done[c+1] = 1'b1;
        exp_to[c+1]   = 1'b1;
        m_armed       = 1'b0;
      end else if (!pwm_lvl) begin
        exp_me[c+1]   = m_rem;
        exp_busy[c+2] = 1'b1;
        exp_done[c+2] = 1'b1;
        m_armed       = 1'b0;
      end else begin
        exp_me[c+1] = hit;
        m_rem       = m_rem & ~hit;
      end
    end
  endtask

  task automatic step(input bit r, input bit rq, input logic [7:0] mk, input logic [1:0] md,
                      input logic [7:0] z, input logic [7:0] pk);
    reset       = r;
    upd_req     = rq;
    upd_chmask  = mk;
    upd_mode    = md;
    carr_zero   = z;
    carr_peak   = pk;
    pwm_on      = pwm_lvl;
    timeout_lim = 16'(lim);
    model(r, rq, mk, md, z, pk);
    @(negedge clk);
    check_eq("maskevent", 32'(maskevent), 32'(exp_me[cyc]));
    check_eq("busy", 32'(upd_busy), 32'(exp_busy[cyc]));
    check_eq("done", 32'(upd_done), 32'(exp_done[cyc]));
    check_eq("timeout", 32'(upd_timeout), 32'(exp_to[cyc]));
    check_eq("reject", 32'(upd_reject), 32'(exp_rej[cyc]));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
  endtask

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    cyc     = 0;
    pwm_lvl = 1'b1;
    lim     = 0;
    m_armed = 1'b0;
    m_start = 0;
    m_rem   = '0;
    m_mode  = '0;
    for (int i = 0; i < NC; i++) begin
      exp_me[i]   = '0;
      exp_done[i] = 1'b0;
      exp_to[i]   = 1'b0;
      exp_rej[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    reset       = 1'b1;
    pwm_on      = 1'b1;
    upd_req     = 1'b0;
    upd_chmask  = '0;
    upd_mode    = '0;
    carr_zero   = '0;
    carr_peak   = '0;
    timeout_lim = '0;
    repeat (2) @(posedge clk);
    #1;

    // Immediate commit.
    idle(3);
    step(1'b0, 1'b1, 8'h05, 2'b00, 8'h00, 8'h00);
    idle(4);
    // Zero mode, staggered channels, peak ignored.
    step(1'b0, 1'b1, 8'h03, 2'b01, 8'h00, 8'h00);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h01, 8'h00);
    idle(3);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h02);
    idle(3);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h02, 8'h00);
    idle(3);
    // Forced commit after four armed cycles.
    lim = 4;
    step(1'b0, 1'b1, 8'h80, 2'b10, 8'h00, 8'h00);
    idle(8);
    // Timeout disabled: stays armed until PWM stops.
    lim = 0;
    step(1'b0, 1'b1, 8'h80, 2'b10, 8'h00, 8'h00);
    idle(20);
    pwm_lvl = 1'b0;
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
    pwm_lvl = 1'b1;
    idle(4);
    // PWM off at request time.
    pwm_lvl = 1'b0;
    step(1'b0, 1'b1, 8'hFF, 2'b11, 8'h00, 8'h00);
    idle(3);
    pwm_lvl = 1'b1;
    // PWM drops mid-ARMED with 0x0C pending.
    step(1'b0, 1'b1, 8'h0D, 2'b01, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h01, 8'h00);
    pwm_lvl = 1'b0;
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
    pwm_lvl = 1'b1;
    idle(4);
    // Reject while armed, pending unchanged; dual events give one strobe.
    step(1'b0, 1'b1, 8'h30, 2'b11, 8'h00, 8'h00);
    idle(2);
    step(1'b0, 1'b1, 8'h0F, 2'b00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h0F, 8'h0F);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'h30, 8'h30);
    idle(3);
    // Reset while armed abandons the request.
    step(1'b0, 1'b1, 8'h30, 2'b01, 8'h00, 8'h00);
    idle(2);
    step(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF, 8'hFF);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] mk;
      logic [7:0] z;
      logic [7:0] pk;
      bit         r;
      bit         rq;
      if (!exp_busy[cyc] && $urandom_range(3) == 0)
        lim = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(10, 1));
      if (pwm_lvl ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0)) pwm_lvl = ~pwm_lvl;
      r  = ($urandom_range(199) == 0);
      rq = ($urandom_range(5) == 0);
      mk = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      z  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      pk = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(r, rq, mk, 2'($urandom_range(3)), z, pk);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_shadow_update_scheduler.md
Name: pwm_shadow_update_scheduler

Overview:
- Sequences the maskevent strobes that commit staged compare values into the per-channel shadow registers of the 8-carrier PWM.
- Accepts one software update request at a time, with a channel mask and a commit mode.
- Waits for the selected carrier events (zero and/or peak) on each masked channel, then issues a one-cycle maskevent per channel and reports completion.
- Sits between the AXI register bank and the shadow-register bank.

Parameters:
N_CH, 8, number of PWM channels / carriers
TIMEOUT_W, 16, width of timeout counter and limit

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pwm_on  input  1  1 = PWM running; 0 = PWM off (shadow registers are transparent)
upd_req  input  1  single-cycle update request pulse
upd_chmask  input  N_CH  channels to update; sampled with upd_req
upd_mode  input  2  00 immediate, 01 at carrier zero, 10 at carrier peak, 11 at zero or peak; sampled with upd_req
carr_zero  input  N_CH  per-channel carrier-zero event pulse
carr_peak  input  N_CH  per-channel carrier-peak event pulse
timeout_lim  input  TIMEOUT_W  max ARMED cycles before forced commit; 0 disables the timeout
maskevent  output  N_CH  registered one-cycle commit strobe per channel
upd_busy  output  1  high whenever state != IDLE
upd_done  output  1  one-cycle pulse when the update completes
upd_timeout  output  1  one-cycle pulse coincident with upd_done when the commit was forced
upd_reject  output  1  one-cycle pulse when upd_req arrives while busy

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; pending, latched mask/mode and timeout counter cleared.
  - All outputs 0. Any operation in flight is abandoned; no maskevent is issued.
- FSM states: IDLE, ARMED, COMMIT, DONE.
- IDLE:
  - upd_req=1 latches upd_chmask into pending and latches upd_mode.
  - If upd_mode=00 or pwm_on=0, go to COMMIT; otherwise go to ARMED. The timeout counter is cleared in both cases.
- COMMIT:
  - maskevent=pending for exactly this one cycle (registered output). Clear pending. Go to DONE.
- ARMED:
  - hit[i] = pending[i] & ((mode[0] & carr_zero[i]) | (mode[1] & carr_peak[i])).
  - maskevent <= hit on the next cycle; pending <= pending & ~hit.
  - Channels commit independently. A channel strobes at most once per request.
  - When pending & ~hit == 0, the next state is DONE. The last maskevent and DONE occupy the same cycle.
  - The timeout counter increments each ARMED cycle (saturating). If timeout_lim != 0 and counter+1 == timeout_lim:
    - maskevent <= pending & ~hit | hit (i.e. all remaining channels); set the timeout flag; go to DONE.
  - If pwm_on falls while ARMED: remaining pending channels commit via the COMMIT path next cycle. This is not a timeout.
- DONE: upd_done=1 for one cycle (upd_timeout=1 as well if forced). Go to IDLE.
- upd_busy = (state != IDLE). upd_busy is still high in the DONE cycle.
- upd_req while busy: ignored, no state change, upd_reject pulses the next cycle.
- upd_req with mask=0: takes the COMMIT path with maskevent=0; upd_done at req+2.
- Latency:
  - Immediate mode: upd_req at cycle N gives maskevent at N+1 and upd_done at N+2.
  - Event mode: an event at cycle k gives maskevent at k+1. upd_done occurs in the same cycle as the final maskevent.
- Simultaneous zero and peak on the same channel in mode 11: a single strobe.
- An event in the same cycle as upd_req is not counted; arming starts the following cycle.

Test Plan:
- Immediate: reset, pwm_on=1, upd_req with mask=0x05, mode=00 at cycle 10 -> maskevent=0x05 at cycle 11 only; upd_done at 12; busy high during 11-12.
- Zero-mode staggered: mask=0x03, mode=01; carr_zero[0] at cycle 20, carr_zero[1] at cycle 35, carr_peak[1] at cycle 25 -> maskevent=0x01 at 21, 0x02 at 36, nothing at 26; upd_done at 36.
- Timeout: mask=0x80, mode=10, timeout_lim=4, no events -> maskevent=0x80 and upd_done=upd_timeout=1 in the 4th cycle after entering ARMED; timeout_lim=0 -> stays busy indefinitely.
- pwm_off paths:
  - pwm_on=0 with mode=11, mask=0xFF -> immediate commit of 0xFF one cycle after the request.
  - pwm_on dropping mid-ARMED with pending=0x0C -> maskevent=0x0C one cycle later, upd_done next, upd_timeout=0.
- Reject/reset: a second upd_req while ARMED -> upd_reject pulse, pending unchanged. Assert reset while ARMED -> all outputs 0 the next cycle; later events produce no maskevent.
